// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: single-outstanding load/store sequencer between the CPU core
// and a 64x16 data RAM. Owns the bidirectional RAM data bus. After every read
// it inserts an idle turnaround gap so the RAM and this block never drive the
// bus in the same cycle.
module ram_bus_ctrl #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 16,
  parameter int READ_LAT  = 2,
  parameter int WRITE_CYC = 1,
  parameter int TURN      = 1
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_busy,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic              ram_re
);

  localparam int MAX_RW = (READ_LAT > WRITE_CYC) ? READ_LAT : WRITE_CYC;
  localparam int MAX_C  = (MAX_RW > TURN) ? MAX_RW : TURN;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  // Counter value that marks the final cycle of each timed state.
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WRITE_CYC - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'((TURN > 0) ? TURN - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_drive;
  logic                r_en;
  logic                r_we;
  logic                r_re;
  logic                r_ready;
  logic                r_busy;

  // The bus is released to high-Z in every state except WRITE; r_drive is a
  // register, so the enable cannot glitch during state changes.
  assign ram_data  = r_drive ? r_wdata : {DATA_W{1'bz}};

  assign cpu_rdata = r_rdata;
  assign cpu_ready = r_ready;
  assign cpu_busy  = r_busy;
  assign ram_addr  = r_addr;
  assign ram_en    = r_en;
  assign ram_we    = r_we;
  assign ram_re    = r_re;

  // Transaction FSM: every strobe is registered with the state it belongs to.
  // NOTE: reset is asynchronous, so a mid-transaction abort drops the strobes
  // and releases the bus without waiting for a clock edge.
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_drive <= 1'b0;
      r_en    <= 1'b0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_en    <= 1'b1;
            if (cpu_we) begin
              r_state <= S_WRITE;
              r_we    <= 1'b1;
              r_drive <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_re    <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          if (r_cnt == W_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_we    <= 1'b0;
            r_drive <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_READ: begin
          if (r_cnt == R_LAST) begin
            r_rdata <= ram_data;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_re    <= 1'b0;
            r_ready <= 1'b1;
            if (TURN > 0) begin
              r_state <= S_TURN;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_TURN: begin
          if (r_cnt == T_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_en    <= 1'b0;
          r_we    <= 1'b0;
          r_re    <= 1'b0;
          r_drive <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
